reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-read-port register file with a hardware clear sequence, optional write-to-read bypass and a per-register pending-write scoreboard. It replaces the single-configuration integer register file in the decode stage. Read data is registered for the execute stage, and each read carries a busy flag so the hazard unit can stall on outstanding producers.

## Interface
- WORD_WIDTH, 32, data word width
- ADDR_WIDTH, 5, register address width; NREGS = 1 << ADDR_WIDTH
- NREAD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a read of the register being written this cycle returns the new data; 0 = returns the old data
- ZERO_REG, 1, 1 = register 0 reads as 0, is never written and is never busy

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- ready  out  1  high once the clear sequence has finished
- w_en  in  1  write enable
- wa  in  ADDR_WIDTH  write address
- wd  in  WORD_WIDTH  write data
- mark_en  in  1  set the scoreboard busy bit of mark_addr
- mark_addr  in  ADDR_WIDTH  register gaining a pending producer
- ra  in  NREAD*ADDR_WIDTH  read addresses; port i is at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd  out  NREAD*WORD_WIDTH  registered read data; port i is at [i*WORD_WIDTH +: WORD_WIDTH]
- rd_busy  out  NREAD  registered busy flag per read port

## Operation
- **FSM states:** CLEAR, RUN.
- **Reset (rst_n low, asynchronous):**
  - state = CLEAR, clr_ptr = 0
  - ready = 0, rd = 0, rd_busy = 0
  - all scoreboard bits = 0
  - array contents are not reset directly; the CLEAR state zeroes them.
- **CLEAR:**
  - Each cycle: regs[clr_ptr] <= 0, clr_ptr++.
  - After the cycle that writes regs[NREGS-1], go to RUN and set ready = 1.
  - w_en, mark_en and ra are ignored; rd and rd_busy hold 0.
- **RUN, write:** regs[wa] <= wd when w_en, unless ZERO_REG and wa == 0.
- **RUN, read port i:** rd[i] <= first matching rule:
  1. 0, if ZERO_REG and ra_i == 0
  2. wd, if BYPASS and w_en and wa == ra_i
  3. regs[ra_i] (pre-edge value)
- **Scoreboard, per edge in RUN:**
  - busy_next = busy
  - if w_en: busy_next[wa] = 0
  - then if mark_en: busy_next[mark_addr] = 1 (mark wins on same address)
  - with ZERO_REG, busy_next[0] is forced to 0
  - busy <= busy_next
- **rd_busy[i] <= busy_next[ra_i]:** the flag reflects this edge's write and mark.
- **Multiple ports:** any number of ports may read the same address; all see identical data and flag.
- **Width:** NREAD*WORD_WIDTH flat buses, no truncation. clr_ptr is ADDR_WIDTH+1 bits so the end of the sweep is detectable.

## Timing
- **Read latency:** 1 cycle. ra presented before edge N gives rd valid after edge N.
- **Write latency:**
  - Array updates at the edge where w_en is sampled.
  - A read of the same address in the following cycle returns the new data regardless of BYPASS.
- **Clear duration:**
  - rst_n deassertion is followed by exactly NREGS rising edges in CLEAR.
  - ready rises after the NREGS-th edge (32 edges at default parameters).
- **Reset during RUN or CLEAR:**
  - Outputs go to reset values immediately, without waiting for an edge.
  - The clear sequence restarts from 0 after deassertion.
- **Handshake:**
  - Upstream must hold w_en and mark_en low until ready is high.
  - Any requests issued earlier are dropped, with no error flag.

## Test plan
1. **Clear:** release rst_n and count edges → ready rises after exactly 32 edges; then read r1..r31 → all 0, rd_busy 0.
2. **Write/read:** write r5 = 0xDEADBEEF; next cycle ra0 = 5 → rd0 = 0xDEADBEEF one cycle later.
3. **Bypass:**
   - Same cycle: w_en, wa = 7, wd = 0x1234, ra1 = 7.
   - BYPASS=1 → rd1 = 0x1234.
   - BYPASS=0 → rd1 = old value 0.
4. **Zero register:**
   - Write r0 = 0xFFFFFFFF, mark_addr = 0 → rd = 0 and rd_busy = 0 on later reads of r0.
   - With ZERO_REG=0 → reads return 0xFFFFFFFF.
5. **Scoreboard:**
   - mark r3, then ra0 = 3 → rd_busy0 = 1.
   - Write r3 → rd_busy0 = 0 in that same cycle's read.
   - Same edge w_en wa = 3 and mark_en mark_addr = 3 → rd_busy0 = 1.
6. **Mid-operation reset:**
   - Write r9 = 0xA5, mark r9, pulse rst_n low mid-cycle → ready, rd and rd_busy go to 0 asynchronously.
   - After a fresh 32-edge clear, r9 reads 0 and is not busy.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with power-up clear sweep, optional write bypass and pending-write scoreboard.
// Reads take 1 cycle and are registered. There is no backpressure: requests are dropped until ready is high.
module reg_file_mp #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NREAD      = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          ready,
  input  logic                          w_en,
  input  logic [ADDR_WIDTH-1:0]         wa,
  input  logic [WORD_WIDTH-1:0]         wd,
  input  logic                          mark_en,
  input  logic [ADDR_WIDTH-1:0]         mark_addr,
  input  logic [NREAD*ADDR_WIDTH-1:0]   ra,
  output logic [NREAD*WORD_WIDTH-1:0]   rd,
  output logic [NREAD-1:0]              rd_busy
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(NREGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                      state;
  logic [ADDR_WIDTH:0]         clr_ptr;
  logic [WORD_WIDTH-1:0]       regs [NREGS];
  logic [NREGS-1:0]            busy;
  logic [NREGS-1:0]            busy_next;
  logic [NREAD*WORD_WIDTH-1:0] rd_next;
  logic [NREAD-1:0]            rd_busy_next;
  logic                        wr_ok;

  // Register 0 is hardwired when ZERO_REG is set, so writes to it are discarded.
  assign wr_ok = w_en && !((ZERO_REG != 0) && (wa == '0));

  always_comb begin
    busy_next = busy;
    if (w_en) busy_next[wa] = 1'b0;
    if (mark_en) busy_next[mark_addr] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  always_comb begin
    rd_next      = '0;
    rd_busy_next = '0;
    for (int i = 0; i < NREAD; i++) begin
      if ((ZERO_REG != 0) && (ra[i*ADDR_WIDTH +: ADDR_WIDTH] == '0))
        rd_next[i*WORD_WIDTH +: WORD_WIDTH] = '0;
      else if ((BYPASS != 0) && w_en && (wa == ra[i*ADDR_WIDTH +: ADDR_WIDTH]))
        rd_next[i*WORD_WIDTH +: WORD_WIDTH] = wd;
      else
        rd_next[i*WORD_WIDTH +: WORD_WIDTH] = regs[ra[i*ADDR_WIDTH +: ADDR_WIDTH]];
      rd_busy_next[i] = busy_next[ra[i*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  // The array has no reset; the CLEAR sweep zeroes one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      regs[clr_ptr[ADDR_WIDTH-1:0]] <= '0;
    else if (wr_ok)
      regs[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
      rd      <= '0;
      rd_busy <= '0;
      busy    <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          rd      <= '0;
          rd_busy <= '0;
          if (clr_ptr == CLR_LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          busy    <= busy_next;
          rd      <= rd_next;
          rd_busy <= rd_busy_next;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default instance plus a BYPASS=0 / ZERO_REG=0 instance on shared inputs.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_en;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic [9:0]  ra;
  logic        ready, ready_b;
  logic [63:0] rd, rd_b;
  logic [1:0]  rd_busy, rd_busy_b;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .w_en(w_en), .wa(wa), .wd(wd),
    .mark_en(mark_en), .mark_addr(mark_addr), .ra(ra), .rd(rd), .rd_busy(rd_busy)
  );

  reg_file_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ready(ready_b), .w_en(w_en), .wa(wa), .wd(wd),
    .mark_en(mark_en), .mark_addr(mark_addr), .ra(ra), .rd(rd_b), .rd_busy(rd_busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_clear(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 100) begin
      step();
      n++;
      if (ready) break;
    end
    chk({tag, "_edges"}, 64'(n), 64'd32);
    chk({tag, "_ready_b"}, 64'(ready_b), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; w_en = 1'b0; wa = '0; wd = '0;
    mark_en = 1'b0; mark_addr = '0; ra = '0;
    #3;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rd", rd, 64'd0);
    chk("rst_busy", 64'(rd_busy), 64'd0);
    #10;

    // Clear sweep and read-back of every register
    run_clear("clear");
    for (int a = 0; a < 32; a += 2) begin
      ra = {5'(a + 1), 5'(a)};
      step();
      chk("clear_rd", rd, 64'd0);
      chk("clear_busy", 64'(rd_busy), 64'd0);
      chk("clear_rd_b", rd_b, 64'd0);
      chk("clear_busy_b", 64'(rd_busy_b), 64'd0);
    end

    // Write then read
    w_en = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = '0;
    step();
    w_en = 1'b0; ra = {5'd0, 5'd5};
    step();
    chk("wr_rd0", 64'(rd[31:0]), 64'hDEADBEEF);
    chk("wr_rd0_b", 64'(rd_b[31:0]), 64'hDEADBEEF);

    // Same-cycle bypass
    w_en = 1'b1; wa = 5'd7; wd = 32'h1234; ra = {5'd7, 5'd5};
    step();
    chk("byp_rd", rd, {32'h1234, 32'hDEADBEEF});
    chk("nobyp_rd_b", rd_b, {32'h0, 32'hDEADBEEF});
    w_en = 1'b0;
    step();
    chk("byp_after_b", 64'(rd_b[63:32]), 64'h1234);

    // Register 0 write and mark
    w_en = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; mark_en = 1'b1; mark_addr = 5'd0; ra = '0;
    step();
    chk("z_rd", rd, 64'd0);
    chk("z_busy", 64'(rd_busy), 64'd0);
    chk("z_rd_b", rd_b, 64'd0);
    chk("z_busy_b", 64'(rd_busy_b), 64'd3);
    w_en = 1'b0; mark_en = 1'b0;
    step();
    chk("z2_rd", rd, 64'd0);
    chk("z2_busy", 64'(rd_busy), 64'd0);
    chk("z2_rd_b", rd_b, 64'hFFFFFFFF_FFFFFFFF);
    chk("z2_busy_b", 64'(rd_busy_b), 64'd3);

    // Scoreboard
    mark_en = 1'b1; mark_addr = 5'd3;
    step();
    mark_en = 1'b0; ra = {5'd0, 5'd3};
    step();
    chk("sb_mark", 64'(rd_busy), 64'd1);
    chk("sb_mark_b", 64'(rd_busy_b), 64'd3);
    w_en = 1'b1; wa = 5'd3; wd = 32'h33;
    step();
    chk("sb_wr_busy", 64'(rd_busy), 64'd0);
    chk("sb_wr_busy_b", 64'(rd_busy_b), 64'd2);
    chk("sb_wr_rd", 64'(rd[31:0]), 64'h33);
    chk("sb_wr_rd_b", 64'(rd_b[31:0]), 64'h0);
    wd = 32'h44; mark_en = 1'b1;
    step();
    chk("sb_both_busy", 64'(rd_busy), 64'd1);
    chk("sb_both_busy_b", 64'(rd_busy_b), 64'd3);
    w_en = 1'b0; mark_en = 1'b0; ra = {5'd3, 5'd3};
    step();
    chk("mp_rd", rd, {32'h44, 32'h44});
    chk("mp_busy", 64'(rd_busy), 64'd3);
    chk("mp_rd_b", rd_b, {32'h44, 32'h44});

    // Mid-operation reset
    w_en = 1'b1; wa = 5'd9; wd = 32'hA5; mark_en = 1'b1; mark_addr = 5'd9; ra = {5'd9, 5'd9};
    step();
    chk("r9_rd", rd, {32'hA5, 32'hA5});
    chk("r9_busy", 64'(rd_busy), 64'd3);
    chk("r9_rd_b", rd_b, 64'd0);
    w_en = 1'b0; mark_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(ready), 64'd0);
    chk("arst_rd", rd, 64'd0);
    chk("arst_busy", 64'(rd_busy), 64'd0);
    chk("arst_ready_b", 64'(ready_b), 64'd0);
    chk("arst_rd_b", rd_b, 64'd0);
    chk("arst_busy_b", 64'(rd_busy_b), 64'd0);
    run_clear("reclear");
    ra = {5'd3, 5'd9};
    step();
    chk("post_rd", rd, 64'd0);
    chk("post_busy", 64'(rd_busy), 64'd0);
    chk("post_rd_b", rd_b, 64'd0);
    chk("post_busy_b", 64'(rd_busy_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
